// File: rtl/rv32_bus_pkg.sv
// Shared types and the byte-strobe legality check for the RV32 data-memory bus adapter.
package rv32_bus_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} dmem_state_t;

  localparam logic [3:0] STRB_LOAD = 4'b0000;
  localparam logic [3:0] STRB_B0   = 4'b0001;
  localparam logic [3:0] STRB_B1   = 4'b0010;
  localparam logic [3:0] STRB_B2   = 4'b0100;
  localparam logic [3:0] STRB_B3   = 4'b1000;
  localparam logic [3:0] STRB_H0   = 4'b0011;
  localparam logic [3:0] STRB_H1   = 4'b1100;
  localparam logic [3:0] STRB_W    = 4'b1111;

  // Halfwords must be 2-byte aligned, words 4-byte aligned; anything else faults.
  function automatic logic strb_legal(input logic [3:0] we, input logic [1:0] addr);
    logic ok;
    case (we)
      STRB_LOAD, STRB_B0, STRB_B1, STRB_B2, STRB_B3: ok = 1'b1;
      STRB_H0, STRB_H1:                              ok = ~addr[0];
      STRB_W:                                        ok = (addr == 2'b00);
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv32_dmem_bus_adapter.sv
// Converts single-cycle core loads/stores into req/gnt + rvalid bus transactions,
// stalling the core until completion and bounding the response wait with a timeout.
module rv32_dmem_bus_adapter
  import rv32_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic [3:0]  core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_stall_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic        bus_req_o,
  output logic [3:0]  bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  localparam bit                  TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

  dmem_state_t         state;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                to_fire;

  // Fires in the TIMEOUT_CYCLES-th RESP cycle; a same-cycle rvalid still takes priority.
  assign to_fire = TO_EN && ((to_cnt + TO_WIDTH'(1)) == TO_LIMIT);

  assign core_stall_o = ((state == IDLE) && core_req_i) || (state == REQ) || (state == RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      to_cnt        <= '0;
      core_rvalid_o <= 1'b0;
      core_rdata_o  <= '0;
      core_err_o    <= 1'b0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= '0;
      bus_addr_o    <= '0;
      bus_wdata_o   <= '0;
    end else begin
      core_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req_i) begin
            if (strb_legal(core_we_i, core_addr_i[1:0])) begin
              state       <= REQ;
              bus_req_o   <= 1'b1;
              bus_we_o    <= core_we_i;
              bus_addr_o  <= {core_addr_i[31:2], 2'b00};
              bus_wdata_o <= core_wdata_i;
            end else begin
              state         <= DONE;
              core_rvalid_o <= 1'b1;
              core_rdata_o  <= '0;
              core_err_o    <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            if (bus_rvalid_i) begin
              state         <= DONE;
              core_rvalid_o <= 1'b1;
              core_rdata_o  <= bus_rdata_i;
              core_err_o    <= bus_err_i;
            end else begin
              state  <= RESP;
              to_cnt <= '0;
            end
          end
        end
        RESP: begin
          if (bus_rvalid_i) begin
            state         <= DONE;
            core_rvalid_o <= 1'b1;
            core_rdata_o  <= bus_rdata_i;
            core_err_o    <= bus_err_i;
          end else if (to_fire) begin
            state         <= DONE;
            core_rvalid_o <= 1'b1;
            core_rdata_o  <= '0;
            core_err_o    <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_dmem_bus_adapter.sv
// Scoreboarded bench for the data-memory bus adapter, run with a 4-cycle response timeout.
module tb_rv32_dmem_bus_adapter;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic [3:0]  core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_seen   = 0;
  resp_t sb[$];
  resp_t mon_exp;
  logic [3:0]  ill_we   [5];
  logic [31:0] ill_addr [5];

  always #5 clk = ~clk;

  rv32_dmem_bus_adapter #(.TIMEOUT_CYCLES(4), .TO_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_stall_o(core_stall), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_err_o(core_err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
  );

  // Every completion pulse is checked against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (core_rvalid === 1'b1) begin
      n_checks++;
      n_seen++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got rdata=%h err=%b, wanted no completion", core_rdata, core_err);
      end else begin
        mon_exp = sb.pop_front();
        if ({core_rdata, core_err} !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_resp: got rdata=%h err=%b, want rdata=%h err=%b",
                   core_rdata, core_err, mon_exp.rdata, mon_exp.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] rdata, input logic err);
    resp_t r;
    r.rdata = rdata;
    r.err   = err;
    sb.push_back(r);
    n_pushed++;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 4'h0; core_addr = '0; core_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
  endtask

  // Plain load: grant in REQ, response in the first RESP cycle.
  task automatic run_load(input logic [31:0] addr, input logic [31:0] rdata);
    tick(); core_req = 1'b1; core_we = 4'h0; core_addr = addr; push(rdata, 1'b0);
    tick(); bus_gnt = 1'b1;
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdata;
    tick(); bus_rvalid = 1'b0; bus_rdata = '0;
    tick(); core_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({core_stall, core_rvalid, core_rdata, core_err, bus_req, bus_we, bus_addr, bus_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall=%b rvalid=%b req=%b addr=%h, want all 0",
               core_stall, core_rvalid, bus_req, bus_addr);
    end
    tick(); rst = 1'b0;
  endtask

  task automatic test_load();
    tick(); core_req = 1'b1; core_we = 4'h0; core_addr = 32'h1000_0004; push(32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({core_stall, bus_req} !== 2'b10) begin
      n_fail++; $display("FAIL load_t0: got stall=%b req=%b, want 1 0", core_stall, bus_req);
    end
    tick(); bus_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({core_stall, bus_req, bus_we, bus_addr} !== {1'b1, 1'b1, 4'h0, 32'h1000_0004}) begin
      n_fail++; $display("FAIL load_t1: got stall=%b req=%b we=%b addr=%h, want 1 1 0000 10000004",
                         core_stall, bus_req, bus_we, bus_addr);
    end
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if ({core_stall, bus_req, core_rvalid} !== 3'b100) begin
      n_fail++; $display("FAIL load_t2: got stall=%b req=%b rvalid=%b, want 1 0 0", core_stall, bus_req, core_rvalid);
    end
    tick(); bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({core_stall, core_rvalid} !== 2'b01) begin
      n_fail++; $display("FAIL load_t3: got stall=%b rvalid=%b, want 0 1", core_stall, core_rvalid);
    end
    tick(); core_req = 1'b0;
  endtask

  task automatic test_illegal_strobe();
    ill_we   = '{4'b1111, 4'b0011, 4'b1100, 4'b0101, 4'b1111};
    ill_addr = '{32'h0000_1003, 32'h0000_2001, 32'h0000_3003, 32'h0000_4000, 32'h0000_5002};
    for (int i = 0; i < 5; i++) begin
      tick(); core_req = 1'b1; core_we = ill_we[i]; core_addr = ill_addr[i]; core_wdata = 32'hFFFF_FFFF;
      push(32'h0, 1'b1);
      @(negedge clk);
      n_checks++;
      if ({core_stall, bus_req} !== 2'b10) begin
        n_fail++; $display("FAIL illegal_t0[%0d]: got stall=%b req=%b, want 1 0", i, core_stall, bus_req);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({core_rvalid, core_stall, bus_req} !== 3'b100) begin
        n_fail++; $display("FAIL illegal_t1[%0d]: got rvalid=%b stall=%b req=%b, want 1 0 0",
                           i, core_rvalid, core_stall, bus_req);
      end
      tick(); core_req = 1'b0;
    end
  endtask

  task automatic test_zero_wait();
    tick(); core_req = 1'b1; core_we = 4'b1100; core_addr = 32'h2000_0006; core_wdata = 32'h1234_0000;
    push(32'h0, 1'b0);
    tick(); bus_gnt = 1'b1; bus_rvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata} !== {1'b1, 4'b1100, 32'h2000_0004, 32'h1234_0000}) begin
      n_fail++; $display("FAIL zw_t1: got req=%b we=%b addr=%h wdata=%h, want 1 1100 20000004 12340000",
                         bus_req, bus_we, bus_addr, bus_wdata);
    end
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({core_rvalid, bus_req, core_stall} !== 3'b100) begin
      n_fail++; $display("FAIL zw_t2: got rvalid=%b req=%b stall=%b, want 1 0 0", core_rvalid, bus_req, core_stall);
    end
    tick(); core_req = 1'b0;
  endtask

  task automatic test_gnt_wait();
    tick(); core_req = 1'b1; core_we = 4'b0010; core_addr = 32'h3000_0005; core_wdata = 32'h0000_AB00;
    push(32'h55AA_33CC, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      // A stray response before the grant must not complete the access.
      bus_rvalid = (k == 0); bus_rdata = (k == 0) ? 32'hBAD0_BAD0 : 32'h0;
      @(negedge clk);
      n_checks++;
      if ({bus_req, bus_we, bus_addr, bus_wdata, core_rvalid} !== {1'b1, 4'b0010, 32'h3000_0004, 32'h0000_AB00, 1'b0}) begin
        n_fail++; $display("FAIL gnt_wait[%0d]: got req=%b we=%b addr=%h wdata=%h rvalid=%b, want 1 0010 30000004 0000ab00 0",
                           k, bus_req, bus_we, bus_addr, bus_wdata, core_rvalid);
      end
    end
    tick(); bus_rvalid = 1'b0; bus_rdata = '0; bus_gnt = 1'b1;
    tick(); bus_gnt = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({core_stall, core_rvalid, bus_req} !== 3'b100) begin
      n_fail++; $display("FAIL gnt_wait_resp: got stall=%b rvalid=%b req=%b, want 1 0 0", core_stall, core_rvalid, bus_req);
    end
    tick(); bus_rvalid = 1'b1; bus_rdata = 32'h55AA_33CC;
    tick(); bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    n_checks++;
    if (core_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL gnt_wait_done: got rvalid=%b, want 1", core_rvalid);
    end
    tick(); core_req = 1'b0;
  endtask

  task automatic test_timeout();
    for (int v = 0; v < 2; v++) begin
      tick(); core_req = 1'b1; core_we = 4'h0; core_addr = 32'h4000_0000;
      if (v == 0) push(32'h0, 1'b1);
      else        push(32'h0BAD_F00D, 1'b0);
      tick(); bus_gnt = 1'b1;
      tick(); bus_gnt = 1'b0; bus_rdata = 32'hFFFF_FFFF;
      for (int k = 0; k < 4; k++) begin
        if (v == 1 && k == 3) begin
          bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
        end
        @(negedge clk);
        n_checks++;
        if ({core_stall, core_rvalid} !== 2'b10) begin
          n_fail++; $display("FAIL timeout_wait[%0d][%0d]: got stall=%b rvalid=%b, want 1 0", v, k, core_stall, core_rvalid);
        end
        tick(); bus_rvalid = 1'b0;
      end
      bus_rdata = '0;
      @(negedge clk);
      n_checks++;
      if ({core_rvalid, core_err} !== {1'b1, (v == 0)}) begin
        n_fail++; $display("FAIL timeout_done[%0d]: got rvalid=%b err=%b, want 1 %0d", v, core_rvalid, core_err, (v == 0));
      end
      tick(); core_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    tick(); core_req = 1'b1; core_we = 4'h0; core_addr = 32'h5000_0008;
    tick(); bus_gnt = 1'b1;
    tick(); bus_gnt = 1'b0; rst = 1'b1; core_req = 1'b0;
    tick(); rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111; bus_err = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({core_stall, core_rvalid, core_rdata, core_err, bus_req, bus_we, bus_addr, bus_wdata} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got stall=%b rvalid=%b req=%b addr=%h, want all 0",
                         core_stall, core_rvalid, bus_req, bus_addr);
    end
    tick(); bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({core_rvalid, bus_req} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_stray: got rvalid=%b req=%b, want 0 0", core_rvalid, bus_req);
    end
    run_load(32'h5000_000C, 32'h2222_2222);
  endtask

  task automatic test_back_to_back();
    tick(); core_req = 1'b1; core_we = 4'h0; core_addr = 32'h6000_0000; push(32'h0000_0001, 1'b0);
    tick(); bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0001;
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({core_rvalid, core_stall} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_done1: got rvalid=%b stall=%b, want 1 0", core_rvalid, core_stall);
    end
    tick(); core_addr = 32'h6000_0010; push(32'h0000_0002, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({core_stall, bus_req} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_bubble: got stall=%b req=%b, want 1 0", core_stall, bus_req);
    end
    tick(); bus_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus_req, bus_addr} !== {1'b1, 32'h6000_0010}) begin
      n_fail++; $display("FAIL b2b_req2: got req=%b addr=%h, want 1 60000010", bus_req, bus_addr);
    end
    tick(); bus_gnt = 1'b0;
    tick(); bus_rvalid = 1'b1; bus_rdata = 32'h0000_0002; bus_err = 1'b1;
    tick(); bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({core_rvalid, core_err} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_done2: got rvalid=%b err=%b, want 1 1", core_rvalid, core_err);
    end
    tick(); core_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_illegal_strobe();
    test_zero_wait();
    test_gnt_wait();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (3) tick();
    n_checks++;
    if (sb.size() != 0 || n_seen != n_pushed) begin
      n_fail++; $display("FAIL sb_drain: got %0d completions with %0d pending, want %0d completions and 0 pending",
                         n_seen, sb.size(), n_pushed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
